gx4000_dma_sound_channel: RTL and testbench

One Plus-ASIC DMA sound channel for the GX4000/CPC+ core. It fetches 16-bit sound-list instructions from system RAM, executes one instruction per scan line, and issues PSG register writes. It sits directly upstream of the PSG. The PSG output is the `cpc_audio_l/r` stream consumed by the GX4000 audio mixer. Three instances, one per channel, are planned.

---
 rtl/gx4000_dma_sound_channel.sv | 277 +++++++++++++++++++++++++++
 tb/tb_gx4000_dma_sound_channel.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx4000_dma_sound_channel.sv
// Plus-ASIC DMA sound channel: walks a sound list in RAM, executing one 16-bit
// instruction per scan line and turning LOAD instructions into PSG register writes.
module gx4000_dma_sound_channel #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              enable,
    input  logic              line_tick,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              cfg_addr_wr,
    input  logic [7:0]        cfg_prescale,
    input  logic              irq_clr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    output logic              psg_wr,
    output logic [3:0]        psg_reg,
    output logic [7:0]        psg_data,
    input  logic              psg_ready,
    output logic              irq,
    output logic              active
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_PSGWR = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam logic [3:0]        OP_LOAD    = 4'h0;
    localparam logic [3:0]        OP_PAUSE   = 4'h1;
    localparam logic [3:0]        OP_REPEAT  = 4'h2;
    localparam logic [3:0]        OP_CONTROL = 4'h4;
    localparam logic [ADDR_W-1:0] PTR_STEP   = ADDR_W'(32'd2);
    localparam logic [ADDR_W-1:0] PTR_MASK   = ~ADDR_W'(32'd1);

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] ptr_r, ptr_nxt_s;
    logic [ADDR_W-1:0] loop_addr_r, loop_addr_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [11:0]       loop_cnt_r, loop_cnt_nxt_s;
    logic [11:0]       pause_cnt_r, pause_cnt_nxt_s;
    logic [7:0]        presc_cnt_r, presc_cnt_nxt_s;
    logic [15:0]       instr_r, instr_nxt_s;
    logic              pending_r, pending_nxt_s;
    logic              drop_r, drop_nxt_s;
    logic              enable_d_r;
    logic              mem_req_r, mem_req_nxt_s;
    logic              psg_wr_r, psg_wr_nxt_s;
    logic [3:0]        psg_reg_r, psg_reg_nxt_s;
    logic [7:0]        psg_data_r, psg_data_nxt_s;
    logic              irq_r, irq_nxt_s;
    logic              active_r, active_nxt_s;

    logic              abort_s;
    logic              busy_s;
    logic              go_idle_s;
    logic [3:0]        opcode_s;
    logic [11:0]       operand_s;
    logic [11:0]       loop_dec_s;

    assign opcode_s   = instr_r[15:12];
    assign operand_s  = instr_r[11:0];
    assign loop_dec_s = loop_cnt_r - 12'd1;
    // A disable seen at any point of a run is remembered until the channel is back in IDLE.
    assign abort_s    = drop_r | ~enable;
    assign busy_s     = (state_r == ST_FETCH) || (state_r == ST_EXEC) || (state_r == ST_PSGWR);

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign psg_wr   = psg_wr_r;
    assign psg_reg  = psg_reg_r;
    assign psg_data = psg_data_r;
    assign irq      = irq_r;
    assign active   = active_r;

    // Next-state and next-register computation for the sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        ptr_nxt_s       = ptr_r;
        loop_addr_nxt_s = loop_addr_r;
        loop_cnt_nxt_s  = loop_cnt_r;
        pause_cnt_nxt_s = pause_cnt_r;
        presc_cnt_nxt_s = presc_cnt_r;
        instr_nxt_s     = instr_r;
        mem_req_nxt_s   = mem_req_r;
        psg_wr_nxt_s    = psg_wr_r;
        psg_reg_nxt_s   = psg_reg_r;
        psg_data_nxt_s  = psg_data_r;
        active_nxt_s    = active_r;
        go_idle_s       = 1'b0;

        if (busy_s && line_tick) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
        end

        if ((state_r != ST_IDLE) && !enable) begin
            drop_nxt_s = 1'b1;
        end else begin
            drop_nxt_s = drop_r;
        end

        if (irq_clr) begin
            irq_nxt_s = 1'b0;
        end else begin
            irq_nxt_s = irq_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (enable && !enable_d_r) begin
                    active_nxt_s = 1'b1;
                    state_nxt_s  = ST_WAIT;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (abort_s) begin
                    go_idle_s = 1'b1;
                end else if (line_tick || pending_r) begin
                    state_nxt_s   = ST_FETCH;
                    mem_req_nxt_s = 1'b1;
                    pending_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = ST_WAIT;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    mem_req_nxt_s = 1'b0;
                    instr_nxt_s   = mem_data;
                    ptr_nxt_s     = ptr_r + PTR_STEP;
                    go_idle_s     = abort_s;
                    state_nxt_s   = ST_EXEC;
                end else begin
                    mem_req_nxt_s = 1'b1;
                end
            end
            ST_EXEC: begin
                if (abort_s) begin
                    go_idle_s = 1'b1;
                end else begin
                    case (opcode_s)
                        OP_LOAD: begin
                            psg_wr_nxt_s   = 1'b1;
                            psg_reg_nxt_s  = operand_s[11:8];
                            psg_data_nxt_s = operand_s[7:0];
                            state_nxt_s    = ST_PSGWR;
                        end
                        OP_PAUSE: begin
                            if (operand_s == 12'd0) begin
                                state_nxt_s     = ST_WAIT;
                            end else begin
                                pause_cnt_nxt_s = operand_s;
                                presc_cnt_nxt_s = cfg_prescale;
                                state_nxt_s     = ST_PAUSE;
                            end
                        end
                        OP_REPEAT: begin
                            loop_cnt_nxt_s  = operand_s;
                            loop_addr_nxt_s = ptr_r;
                            state_nxt_s     = ST_WAIT;
                        end
                        OP_CONTROL: begin
                            // LOOP, then INT, then STOP; the last pass of a loop falls through.
                            if (instr_r[0] && (loop_cnt_r != 12'd0)) begin
                                loop_cnt_nxt_s = loop_dec_s;
                                ptr_nxt_s      = (loop_dec_s != 12'd0) ? loop_addr_r : ptr_r;
                            end else begin
                                loop_cnt_nxt_s = loop_cnt_r;
                            end
                            irq_nxt_s = irq_nxt_s | instr_r[4];
                            if (instr_r[5]) begin
                                go_idle_s   = 1'b1;
                            end else begin
                                state_nxt_s = ST_WAIT;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_WAIT;
                        end
                    endcase
                end
            end
            ST_PSGWR: begin
                if (psg_ready) begin
                    psg_wr_nxt_s = 1'b0;
                    go_idle_s    = abort_s;
                    state_nxt_s  = ST_WAIT;
                end else begin
                    psg_wr_nxt_s = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (abort_s) begin
                    go_idle_s = 1'b1;
                end else if (line_tick) begin
                    if (presc_cnt_r != 8'd0) begin
                        presc_cnt_nxt_s = presc_cnt_r - 8'd1;
                    end else begin
                        presc_cnt_nxt_s = cfg_prescale;
                        pause_cnt_nxt_s = pause_cnt_r - 12'd1;
                        state_nxt_s     = (pause_cnt_r == 12'd1) ? ST_WAIT : ST_PAUSE;
                    end
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: begin
                go_idle_s = 1'b1;
            end
        endcase

        // Leaving a run drops all sequencing state except the list pointer.
        state_nxt_s     = go_idle_s ? ST_IDLE : state_nxt_s;
        active_nxt_s    = go_idle_s ? 1'b0 : active_nxt_s;
        pending_nxt_s   = go_idle_s ? 1'b0 : pending_nxt_s;
        drop_nxt_s      = go_idle_s ? 1'b0 : drop_nxt_s;
        pause_cnt_nxt_s = go_idle_s ? 12'd0 : pause_cnt_nxt_s;
        presc_cnt_nxt_s = go_idle_s ? 8'd0 : presc_cnt_nxt_s;
        loop_cnt_nxt_s  = go_idle_s ? 12'd0 : loop_cnt_nxt_s;
        loop_addr_nxt_s = go_idle_s ? {ADDR_W{1'b0}} : loop_addr_nxt_s;

        ptr_nxt_s       = cfg_addr_wr ? (cfg_addr & PTR_MASK) : ptr_nxt_s;
        mem_addr_nxt_s  = ((state_r == ST_WAIT) && (state_nxt_s == ST_FETCH)) ? ptr_nxt_s : mem_addr_r;
    end

    // Sequencer state, list/loop/pause bookkeeping and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {ADDR_W{1'b0}};
            loop_addr_r <= {ADDR_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            loop_cnt_r  <= 12'd0;
            pause_cnt_r <= 12'd0;
            presc_cnt_r <= 8'd0;
            instr_r     <= 16'd0;
            pending_r   <= 1'b0;
            drop_r      <= 1'b0;
            enable_d_r  <= 1'b0;
            mem_req_r   <= 1'b0;
            psg_wr_r    <= 1'b0;
            psg_reg_r   <= 4'd0;
            psg_data_r  <= 8'd0;
            irq_r       <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            loop_addr_r <= loop_addr_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            loop_cnt_r  <= loop_cnt_nxt_s;
            pause_cnt_r <= pause_cnt_nxt_s;
            presc_cnt_r <= presc_cnt_nxt_s;
            instr_r     <= instr_nxt_s;
            pending_r   <= pending_nxt_s;
            drop_r      <= drop_nxt_s;
            enable_d_r  <= enable;
            mem_req_r   <= mem_req_nxt_s;
            psg_wr_r    <= psg_wr_nxt_s;
            psg_reg_r   <= psg_reg_nxt_s;
            psg_data_r  <= psg_data_nxt_s;
            irq_r       <= irq_nxt_s;
            active_r    <= active_nxt_s;
        end
    end

endmodule

// File: tb/tb_gx4000_dma_sound_channel.sv
// Scoreboard bench for gx4000_dma_sound_channel: a RAM model answers fetches and a
// monitor compares every fetch address and PSG write against queued expectations.
module tb_gx4000_dma_sound_channel;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        line_tick = 1'b0;
    logic [15:0] cfg_addr = 16'h0000;
    logic        cfg_addr_wr = 1'b0;
    logic [7:0]  cfg_prescale = 8'h00;
    logic        irq_clr = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        psg_wr;
    logic [3:0]  psg_reg;
    logic [7:0]  psg_data;
    logic        psg_ready = 1'b1;
    logic        irq;
    logic        active;

    gx4000_dma_sound_channel #(.ADDR_W(16)) dut (
        .clk_sys(clk_sys), .reset(reset), .enable(enable), .line_tick(line_tick),
        .cfg_addr(cfg_addr), .cfg_addr_wr(cfg_addr_wr), .cfg_prescale(cfg_prescale),
        .irq_clr(irq_clr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_data(mem_data), .psg_wr(psg_wr), .psg_reg(psg_reg), .psg_data(psg_data),
        .psg_ready(psg_ready), .irq(irq), .active(active)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_lat = 0;
    bit          ack_hold = 1'b0;
    int          req_cycles = 0;
    int          fetch_cnt = 0;
    logic [15:0] mem_img [logic [15:0]];
    logic [15:0] exp_fetch_q [$];
    logic [11:0] exp_psg_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_tick();
        @(posedge clk_sys); #1; line_tick = 1'b1;
        @(posedge clk_sys); #1; line_tick = 1'b0;
    endtask

    // Tick in cycle T; mem_req must be low in T and high with the given address in T+1.
    task automatic tick_expect_req(input string name, input logic [15:0] addr);
        @(posedge clk_sys); #1; line_tick = 1'b1;
        @(negedge clk_sys);
        check({name, "_req_T"}, 32'(mem_req), 32'd0);
        @(posedge clk_sys); #1; line_tick = 1'b0;
        @(negedge clk_sys);
        check({name, "_req_T1"}, 32'(mem_req), 32'd1);
        check({name, "_addr_T1"}, 32'(mem_addr), 32'(addr));
    endtask

    task automatic start_list(input string name, input logic [15:0] addr);
        @(posedge clk_sys); #1; enable = 1'b0; cfg_addr = addr; cfg_addr_wr = 1'b1;
        @(posedge clk_sys); #1; cfg_addr_wr = 1'b0; enable = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check({name, "_active_start"}, 32'(active), 32'd1);
    endtask

    task automatic wait_ack(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk_sys);
            if (mem_req && mem_ack) seen = 1'b1;
        end
        check({name, "_ack_seen"}, 32'(seen), 32'd1);
    endtask

    // RAM model: acknowledges a request after ack_lat wait cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_data = 16'h0000;
        forever begin
            @(posedge clk_sys); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (mem_req && !ack_hold) begin
                if (wcnt >= ack_lat) begin
                    mem_ack = 1'b1;
                    mem_data = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 16'h4000;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: compares each completed fetch and each accepted PSG write.
    initial begin
        logic [15:0] ea;
        logic [11:0] ep;
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                if (mem_req) req_cycles++;
                if (mem_req && mem_ack) begin
                    fetch_cnt++;
                    if (exp_fetch_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL fetch_unexpected: got addr %0h, expected no fetch", mem_addr);
                    end else begin
                        ea = exp_fetch_q.pop_front();
                        check("fetch_addr", 32'(mem_addr), 32'(ea));
                    end
                end
                if (psg_wr && psg_ready) begin
                    if (exp_psg_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL psg_unexpected: got R%0d=%0h, expected no write", psg_reg, psg_data);
                    end else begin
                        ep = exp_psg_q.pop_front();
                        check("psg_write", 32'({psg_reg, psg_data}), 32'(ep));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int  r0, f0, hold;
        bit  seen;

        // Reset state
        repeat (2) @(negedge clk_sys);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_psg_wr", 32'(psg_wr), 32'd0);
        check("rst_psg_reg", 32'(psg_reg), 32'd0);
        check("rst_psg_data", 32'(psg_data), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        @(posedge clk_sys); #1; reset = 1'b0;
        idle(2);

        // Basic list: two LOADs then STOP, ack latency 2
        ack_lat = 2;
        mem_img[16'h1000] = 16'h07F8; mem_img[16'h1002] = 16'h0855; mem_img[16'h1004] = 16'h4020;
        exp_fetch_q.push_back(16'h1000); exp_fetch_q.push_back(16'h1002); exp_fetch_q.push_back(16'h1004);
        exp_psg_q.push_back(12'h7F8); exp_psg_q.push_back(12'h855);
        start_list("s1", 16'h1000);
        tick_expect_req("s1_t1", 16'h1000);
        idle(8);
        pulse_tick(); idle(8);
        check("s1_active_before_stop", 32'(active), 32'd1);
        pulse_tick(); idle(8);
        check("s1_active_after_stop", 32'(active), 32'd0);

        // Zero-wait LOAD timing, then PAUSE 3 with prescale 1
        ack_lat = 0; cfg_prescale = 8'd1;
        mem_img[16'h2000] = 16'h0A33; mem_img[16'h2002] = 16'h1003;
        mem_img[16'h2004] = 16'h0C44; mem_img[16'h2006] = 16'h4020;
        exp_fetch_q.push_back(16'h2000); exp_fetch_q.push_back(16'h2002);
        exp_fetch_q.push_back(16'h2004); exp_fetch_q.push_back(16'h2006);
        exp_psg_q.push_back(12'hA33); exp_psg_q.push_back(12'hC44);
        start_list("s2", 16'h2000);
        tick_expect_req("s2_t1", 16'h2000);
        @(negedge clk_sys);
        check("s2_req_T2", 32'(mem_req), 32'd0);
        check("s2_psgwr_T2", 32'(psg_wr), 32'd0);
        @(negedge clk_sys);
        check("s2_psgwr_T3", 32'(psg_wr), 32'd1);
        check("s2_psgreg_T3", 32'({psg_reg, psg_data}), 32'hA33);
        @(negedge clk_sys);
        check("s2_psgwr_T4", 32'(psg_wr), 32'd0);
        idle(4);
        pulse_tick(); idle(6);
        r0 = req_cycles;
        repeat (6) begin
            pulse_tick(); idle(3);
        end
        check("s2_pause_no_req", 32'(req_cycles - r0), 32'd0);
        tick_expect_req("s2_t7", 16'h2004);
        idle(6);
        pulse_tick(); idle(6);
        check("s2_active_after_stop", 32'(active), 32'd0);

        // REPEAT 3 body LOOP, then REPEAT 0
        ack_lat = 1;
        mem_img[16'h3000] = 16'h2003; mem_img[16'h3002] = 16'h0155;
        mem_img[16'h3004] = 16'h4001; mem_img[16'h3006] = 16'h4020;
        exp_fetch_q.push_back(16'h3000);
        repeat (3) begin
            exp_fetch_q.push_back(16'h3002); exp_fetch_q.push_back(16'h3004);
            exp_psg_q.push_back(12'h155);
        end
        exp_fetch_q.push_back(16'h3006);
        start_list("s3", 16'h3000);
        repeat (8) begin
            pulse_tick(); idle(8);
        end
        check("s3_active_after_stop", 32'(active), 32'd0);
        check("s3_psg_q_empty", 32'(exp_psg_q.size()), 32'd0);
        mem_img[16'h3100] = 16'h2000; mem_img[16'h3102] = 16'h0177;
        mem_img[16'h3104] = 16'h4001; mem_img[16'h3106] = 16'h4020;
        exp_fetch_q.push_back(16'h3100); exp_fetch_q.push_back(16'h3102);
        exp_fetch_q.push_back(16'h3104); exp_fetch_q.push_back(16'h3106);
        exp_psg_q.push_back(12'h177);
        start_list("s3b", 16'h3100);
        repeat (4) begin
            pulse_tick(); idle(8);
        end
        check("s3b_active_after_stop", 32'(active), 32'd0);
        check("s3b_fetch_q_empty", 32'(exp_fetch_q.size()), 32'd0);

        // INT timing and set-wins-over-clear
        mem_img[16'h4000] = 16'h4010; mem_img[16'h4002] = 16'h4010; mem_img[16'h4004] = 16'h4020;
        exp_fetch_q.push_back(16'h4000); exp_fetch_q.push_back(16'h4002); exp_fetch_q.push_back(16'h4004);
        start_list("s4", 16'h4000);
        pulse_tick();
        wait_ack("s4_i1");
        @(negedge clk_sys);
        check("s4_irq_A1", 32'(irq), 32'd0);
        @(negedge clk_sys);
        check("s4_irq_A2", 32'(irq), 32'd1);
        @(posedge clk_sys); #1; irq_clr = 1'b1;
        @(posedge clk_sys); #1; irq_clr = 1'b0;
        @(negedge clk_sys);
        check("s4_irq_cleared", 32'(irq), 32'd0);
        idle(4);
        pulse_tick();
        wait_ack("s4_i2");
        @(posedge clk_sys); #1; irq_clr = 1'b1;
        @(posedge clk_sys); #1; irq_clr = 1'b0;
        @(negedge clk_sys);
        check("s4_irq_set_wins", 32'(irq), 32'd1);
        idle(4);
        pulse_tick(); idle(8);
        check("s4_active_after_stop", 32'(active), 32'd0);
        check("s4_irq_kept_after_stop", 32'(irq), 32'd1);
        @(posedge clk_sys); #1; irq_clr = 1'b1;
        @(posedge clk_sys); #1; irq_clr = 1'b0;

        // PSG backpressure with two ticks during the write
        ack_lat = 0;
        mem_img[16'h5000] = 16'h0312; mem_img[16'h5002] = 16'h0413; mem_img[16'h5004] = 16'h4020;
        exp_fetch_q.push_back(16'h5000); exp_fetch_q.push_back(16'h5002); exp_fetch_q.push_back(16'h5004);
        exp_psg_q.push_back(12'h312); exp_psg_q.push_back(12'h413);
        start_list("s5", 16'h5000);
        psg_ready = 1'b0;
        f0 = fetch_cnt;
        pulse_tick();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            if (psg_wr) seen = 1'b1;
        end
        check("s5_psgwr_seen", 32'(seen), 32'd1);
        hold = 1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_sys); #1;
            line_tick = (k == 1 || k == 3);
            psg_ready = (k == 5);
            @(negedge clk_sys);
            if (psg_wr) hold++;
        end
        @(negedge clk_sys);
        check("s5_psgwr_low_after", 32'(psg_wr), 32'd0);
        check("s5_psgwr_hold_cycles", 32'(hold), 32'd6);
        idle(15);
        check("s5_one_pending_fetch", 32'(fetch_cnt - f0), 32'd2);
        pulse_tick(); idle(8);
        check("s5_active_after_stop", 32'(active), 32'd0);

        // Enable dropped mid-fetch: ack honoured, no write, pointer advanced
        ack_lat = 4;
        mem_img[16'h6000] = 16'h0999; mem_img[16'h6002] = 16'h4020;
        exp_fetch_q.push_back(16'h6000); exp_fetch_q.push_back(16'h6002);
        start_list("s6", 16'h6000);
        pulse_tick();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            if (mem_req) seen = 1'b1;
        end
        check("s6_req_seen", 32'(seen), 32'd1);
        @(posedge clk_sys); #1; enable = 1'b0;
        idle(12);
        check("s6_active_dropped", 32'(active), 32'd0);
        check("s6_fetch_q_one_left", 32'(exp_fetch_q.size()), 32'd1);
        @(posedge clk_sys); #1; enable = 1'b1;
        idle(3);
        check("s6_active_reenabled", 32'(active), 32'd1);
        pulse_tick(); idle(12);
        check("s6_active_after_stop", 32'(active), 32'd0);

        // Asynchronous reset during a pending fetch handshake
        ack_lat = 0; ack_hold = 1'b1;
        mem_img[16'h7000] = 16'h4020;
        start_list("s7", 16'h7000);
        pulse_tick();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            if (mem_req) seen = 1'b1;
        end
        check("s7_req_high", 32'(mem_req), 32'd1);
        #2; reset = 1'b1; enable = 1'b0;
        #1;
        check("s7_rst_mem_req", 32'(mem_req), 32'd0);
        check("s7_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("s7_rst_psg_wr", 32'(psg_wr), 32'd0);
        check("s7_rst_irq", 32'(irq), 32'd0);
        check("s7_rst_active", 32'(active), 32'd0);
        idle(2);
        reset = 1'b0; ack_hold = 1'b0;
        idle(4);
        check("s7_post_mem_req", 32'(mem_req), 32'd0);

        check("end_fetch_q_empty", 32'(exp_fetch_q.size()), 32'd0);
        check("end_psg_q_empty", 32'(exp_psg_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
